// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/count/flag control for a 16x3 distributed-RAM FIFO with registered read data.
module fifo_ctrl #(
    parameter int DATA_W = 3,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic              clr_err,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_addr_w,
    output logic [ADDR_W-1:0] ram_addr_r,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic wr_acc, rd_acc;
    logic [ADDR_W:0] count_nxt;
    assign rd_acc = rd_req & ~empty;
    assign wr_acc = wr_req & (~full | rd_acc);
    assign count_nxt = count + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
    assign ram_wr_en = wr_acc & rst_n;
    assign ram_addr_w = wr_ptr;
    assign ram_addr_r = rd_ptr;
    assign ram_din = wr_data;
    // flags come from the next count, never from pointer equality
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            full <= 1'b0;
            empty <= 1'b1;
            rd_data <= '0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr <= wr_acc ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= rd_acc ? rd_ptr + 1'b1 : rd_ptr;
            count <= count_nxt;
            full <= count_nxt == DEPTH;
            empty <= count_nxt == '0;
            rd_data <= rd_acc ? ram_dout : rd_data;
            rd_valid <= rd_acc;
            overflow <= (overflow & ~clr_err) | (wr_req & ~wr_acc);
            underflow <= (underflow & ~clr_err) | (rd_req & ~rd_acc);
        end
    end
endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Control and sequencing block for the 16-entry × 3-bit dual-port distributed-RAM FIFO storage in the Cola_fifo design. Owns the write and read pointers, occupancy count and full/empty flags, and generates the storage's write enable and addresses. Registers the storage's asynchronous read data into a one-cycle-latency output with a valid strobe. Sits between a producer/consumer pair and the storage array.

## Interface
- DATA_W, 3, data word width (matches storage width)
- ADDR_W, 4, pointer width; depth = 2^ADDR_W = 16
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_req  in  1  producer write request; consumed only when accepted
- wr_data  in  DATA_W  producer write data
- rd_req  in  1  consumer read request; consumed only when accepted
- clr_err  in  1  synchronous clear of overflow/underflow
- ram_wr_en  out  1  storage write enable (combinational = write accepted)
- ram_addr_w  out  ADDR_W  storage write/SPO address = wr_ptr
- ram_addr_r  out  ADDR_W  storage DPRA address = rd_ptr
- ram_din  out  DATA_W  storage write data = wr_data (pass-through)
- ram_dout  in  DATA_W  storage DPO (asynchronous read of ram_addr_r)
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  one-cycle strobe: rd_data holds a newly read word
- full  out  1  count == 16
- empty  out  1  count == 0
- count  out  ADDR_W+1  occupancy 0..16
- overflow  out  1  sticky: write requested while rejected
- underflow  out  1  sticky: read requested while rejected

## Operation
- wr_acc = wr_req & (~full | rd_acc); rd_acc = rd_req & ~empty.
- Full + wr_req + rd_req: both accepted, count stays 16.
- Empty + wr_req + rd_req: write accepted, read rejected (underflow set); word is readable from the next cycle.
- wr_acc: storage writes wr_data at wr_ptr on the edge; wr_ptr += 1 mod 16.
- rd_acc: rd_data <= ram_dout (word at rd_ptr); rd_ptr += 1 mod 16; rd_valid <= 1. Otherwise rd_valid <= 0, rd_data holds its value.
- count next = count + wr_acc − rd_acc; full/empty registered from next count (no combinational path from requests to flags).
- Pointers wrap 15→0 without disturbing count; full/empty never derived from pointer equality.
- overflow <= 1 on wr_req & ~wr_acc; underflow <= 1 on rd_req & ~rd_acc; both clear only on clr_err or reset. Event and clr_err in the same cycle: flag set (event wins).
- Reset (any time, including mid-transfer): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. Storage contents are not cleared and are treated as invalid. ram_wr_en is 0 while rst_n is low.

## Timing
- Write-to-visible: write accepted on edge N → empty=0 after edge N → earliest read accepted on edge N+1 → rd_data/rd_valid valid after edge N+1.
- Read latency: one clock from the accepting edge to rd_data/rd_valid.
- ram_wr_en, ram_din: combinational from requests and registered flags; the producer must hold wr_data stable through the edge.
- ram_addr_w/ram_addr_r: registered pointers, stable across the whole cycle.
- Back-to-back: one write and one read accepted per cycle sustained; 16 writes from empty set full after the 16th edge.

## Test plan
- Reset, then write 1..5 on consecutive cycles, then read 5 → rd_data sequence 1,2,3,4,5, each with rd_valid one cycle after rd_req; count 5→0; empty=1 at the end.
- Write 16 words (values i mod 8) → full=1 and count=16 after the 16th edge; a 17th wr_req gives ram_wr_en=0 and overflow=1; clr_err clears it.
- Full with simultaneous wr_req+rd_req for 20 cycles → count stays 16, full stays 1, pointers wrap; drain returns words in write order.
- Empty with simultaneous wr_req(data 6)+rd_req → underflow=1 and count=1; next-cycle read returns 6.
- 24 interleaved write/read cycles crossing address 15→0 → data order preserved; ram_addr_w/ram_addr_r wrap to 0.
- Assert rst_n low mid-stream with count=7 → all outputs take their reset values immediately, independent of clk; after release, a single write/read round-trip returns the new data.
